// File: rtl/timer_preset_controller.sv
// timer_preset_controller
//   Button-driven front end for count_down_timer. Edits a BCD hh:mm:ss
//   preset, issues set/play/stop/reset command pulses through a small
//   two-slot sequencer, and produces per-field display blanking.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   btn_mode/up/down/start   debounced one-cycle button pulses
//   ring, counting           timer feedback (counting is status only)
//   hour/minute/second_bcd   preset value presented to the timer
//   set/play/stop/reset      command pulses, PULSE_CYCLES wide
//   field_blank              {h,m,s} blanking, 1 = field hidden
//   cmd_busy                 sequencer active, buttons ignored
//   state_code               current FSM state
module timer_preset_controller #(
    parameter int CLK_HZ       = 5000000,
    parameter int BLINK_HZ     = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       ring,
    input  logic       counting,
    output logic [7:0] hour_bcd,
    output logic [7:0] minute_bcd,
    output logic [7:0] second_bcd,
    output logic       set,
    output logic       play,
    output logic       stop,
    output logic       reset,
    output logic [2:0] field_blank,
    output logic       cmd_busy,
    output logic [2:0] state_code
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int SW   = $clog2(SMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_H  = 3'd1,
        S_EDIT_M  = 3'd2,
        S_EDIT_S  = 3'd3,
        S_RUNNING = 3'd4,
        S_PAUSED  = 3'd5,
        S_ALARM   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_SET, C_PLAY, C_STOP, C_RESET
    } cmd_t;

    state_t         state, state_nxt;
    cmd_t           q_first, q_second;
    cmd_t           seq_cur, seq_nxt;
    logic           seq_active, seq_gap;
    logic [SW-1:0]  seq_cnt;
    logic [BW-1:0]  blink_cnt;
    logic           blink_phase;
    logic           go_start, go_mode, go_up, go_down;
    logic           preset_zero, pulse_on;

    // counting is informational only; nothing in this block depends on it
    logic unused_counting;
    assign unused_counting = counting;

    // Priority start > mode > up > down; nothing is accepted while busy
    assign go_start = !cmd_busy && btn_start;
    assign go_mode  = !cmd_busy && !btn_start && btn_mode;
    assign go_up    = !cmd_busy && !btn_start && !btn_mode && btn_up;
    assign go_down  = !cmd_busy && !btn_start && !btn_mode && !btn_up && btn_down;

    assign preset_zero = ({hour_bcd, minute_bcd, second_bcd} == 24'h0);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        if (v == 8'h00) return max_v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        q_first   = C_NONE;
        q_second  = C_NONE;
        case (state)
            S_IDLE: begin
                if (go_start) begin
                    if (!preset_zero) begin
                        q_first = C_SET; q_second = C_PLAY; state_nxt = S_RUNNING;
                    end
                end else if (go_mode) begin
                    state_nxt = S_EDIT_H;
                end
            end
            S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
                if (go_start) begin
                    if (!preset_zero) begin
                        q_first = C_SET; q_second = C_PLAY; state_nxt = S_RUNNING;
                    end
                end else if (go_mode) begin
                    case (state)
                        S_EDIT_H: state_nxt = S_EDIT_M;
                        S_EDIT_M: state_nxt = S_EDIT_S;
                        default: begin q_first = C_SET; state_nxt = S_IDLE; end
                    endcase
                end
            end
            S_RUNNING: begin
                if (ring) begin
                    state_nxt = S_ALARM;
                end else if (go_start) begin
                    q_first = C_STOP; state_nxt = S_PAUSED;
                end else if (go_mode) begin
                    q_first = C_RESET; state_nxt = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (go_start) begin
                    q_first = C_PLAY; state_nxt = S_RUNNING;
                end else if (go_mode) begin
                    q_first = C_RESET; state_nxt = S_IDLE;
                end
            end
            S_ALARM: begin
                // Reloading the preset is what clears ring in the timer
                if (go_start || go_mode || go_up || go_down) begin
                    q_first = C_SET; state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Preset edits; only reachable while idle-sequencer, so a set pulse
    // always sees stable BCD values
    always_ff @(posedge clk) begin
        if (rst) begin
            hour_bcd   <= 8'h00;
            minute_bcd <= 8'h00;
            second_bcd <= 8'h00;
        end else if (go_up || go_down) begin
            case (state)
                S_EDIT_H: hour_bcd   <= go_up ? bcd_inc(hour_bcd, 8'h23)   : bcd_dec(hour_bcd, 8'h23);
                S_EDIT_M: minute_bcd <= go_up ? bcd_inc(minute_bcd, 8'h59) : bcd_dec(minute_bcd, 8'h59);
                S_EDIT_S: second_bcd <= go_up ? bcd_inc(second_bcd, 8'h59) : bcd_dec(second_bcd, 8'h59);
                default: ;
            endcase
        end
    end

    // Blink timebase; an edit press restarts it visible so the digit
    // being changed is never hidden at the moment it changes
    always_ff @(posedge clk) begin
        if (rst || go_up || go_down) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        field_blank = 3'b000;
        case (state)
            S_EDIT_H: field_blank = {blink_phase, 2'b00};
            S_EDIT_M: field_blank = {1'b0, blink_phase, 1'b0};
            S_EDIT_S: field_blank = {2'b00, blink_phase};
            S_ALARM:  field_blank = {3{blink_phase}};
            default:  field_blank = 3'b000;
        endcase
    end

    // Command sequencer: pulse phase then gap phase per command; the gap
    // after the last command is part of the busy window. GAP_CYCLES >= 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_active <= 1'b0;
            seq_gap    <= 1'b0;
            seq_cnt    <= '0;
            seq_cur    <= C_NONE;
            seq_nxt    <= C_NONE;
        end else if (q_first != C_NONE) begin
            seq_active <= 1'b1;
            seq_gap    <= 1'b0;
            seq_cnt    <= '0;
            seq_cur    <= q_first;
            seq_nxt    <= q_second;
        end else if (seq_active) begin
            if (!seq_gap) begin
                if (seq_cnt == SW'(PULSE_CYCLES - 1)) begin
                    seq_gap <= 1'b1;
                    seq_cnt <= '0;
                end else begin
                    seq_cnt <= seq_cnt + 1'b1;
                end
            end else if (seq_cnt == SW'(GAP_CYCLES - 1)) begin
                seq_cnt <= '0;
                if (seq_nxt != C_NONE) begin
                    seq_cur <= seq_nxt;
                    seq_nxt <= C_NONE;
                    seq_gap <= 1'b0;
                end else begin
                    seq_active <= 1'b0;
                    seq_gap    <= 1'b0;
                    seq_cur    <= C_NONE;
                end
            end else begin
                seq_cnt <= seq_cnt + 1'b1;
            end
        end
    end

    assign pulse_on   = seq_active && !seq_gap;
    assign set        = pulse_on && (seq_cur == C_SET);
    assign play       = pulse_on && (seq_cur == C_PLAY);
    assign stop       = pulse_on && (seq_cur == C_STOP);
    assign reset      = pulse_on && (seq_cur == C_RESET);
    assign cmd_busy   = seq_active;
    assign state_code = state;

endmodule

// File: tb/tb_timer_preset_controller.sv
`timescale 1ns/1ps
module tb_timer_preset_controller;

    localparam int CLK_HZ = 8, BLINK_HZ = 1, PULSE = 2, GAP = 2;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);

    localparam logic [3:0] K_SET = 4'b1000, K_PLAY = 4'b0100, K_STOP = 4'b0010, K_RESET = 4'b0001;
    localparam logic [3:0] B_START = 4'b1000, B_MODE = 4'b0100, B_UP = 4'b0010, B_DOWN = 4'b0001;

    // Expected command lines for the cycles following a {set, play} accept
    localparam logic [3:0] SEQ_CMD [9] = '{K_SET, K_SET, 4'b0, 4'b0, K_PLAY, K_PLAY, 4'b0, 4'b0, 4'b0};
    localparam logic [8:0] SEQ_BUSY = 9'b011111111;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] h, m, s;
        logic [2:0] blank;
        logic [3:0] cmds;
        logic       busy;
    } snap_t;

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] h, m, s;
    } cmd_t;

    logic clk = 1'b0, rst = 1'b1;
    logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
    logic ring = 1'b0, counting = 1'b0;
    logic [7:0] hour_bcd, minute_bcd, second_bcd;
    logic set, play, stop, reset, cmd_busy;
    logic [2:0] field_blank, state_code;

    logic snap_req = 1'b0, tmo = 1'b0, done = 1'b0;
    int unsigned cyc = 0, blink_ref = 0;
    int n_vec = 0, n_bad = 0;
    snap_t snap_q[$];
    cmd_t  cmd_q[$];

    timer_preset_controller #(
        .CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
        .ring(ring), .counting(counting),
        .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
        .set(set), .play(play), .stop(stop), .reset(reset),
        .field_blank(field_blank), .cmd_busy(cmd_busy), .state_code(state_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Blink phase expected from cycles elapsed since the last restart
    function automatic logic [2:0] exp_blank(input logic [2:0] st);
        logic ph;
        ph = (((cyc - blink_ref) / HALF) % 2) != 0;
        case (st)
            3'd1: return {ph, 2'b00};
            3'd2: return {1'b0, ph, 1'b0};
            3'd3: return {2'b00, ph};
            3'd6: return {3{ph}};
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        blink_ref = cyc;
    endtask

    task automatic press(input logic [3:0] b);
        {btn_start, btn_mode, btn_up, btn_down} = b;
        @(posedge clk); #1;
        {btn_start, btn_mode, btn_up, btn_down} = 4'b0;
        if (b[1] || b[0]) blink_ref = cyc;
    endtask

    task automatic press_n(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic push_cmd(input logic [3:0] k, input logic [7:0] h, m, s);
        cmd_q.push_back({k, h, m, s});
    endtask

    task automatic snap(input logic [2:0] st, input logic [7:0] h, m, s,
                        input logic [3:0] c, input logic b);
        snap_q.push_back({st, h, m, s, exp_blank(st), c, b});
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (cmd_busy && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (cmd_busy) begin
            tmo = 1'b1;
            @(posedge clk); #1;
            tmo = 1'b0;
        end
    endtask

    // Stimulus
    initial begin
        do_reset();
        snap(0, 8'h00, 8'h00, 8'h00, 4'b0, 1'b0);

        // 1: basic editing
        press(B_MODE);
        press_n(B_UP, 3);
        press(B_MODE);
        press(B_DOWN);
        press(B_MODE);
        press_n(B_UP, 12);
        snap(3, 8'h03, 8'h59, 8'h12, 4'b0, 1'b0);

        // 2: wrap behaviour
        push_cmd(K_SET, 8'h03, 8'h59, 8'h12);
        press(B_MODE);
        wait_idle();
        snap(0, 8'h03, 8'h59, 8'h12, 4'b0, 1'b0);
        press(B_MODE);
        press_n(B_DOWN, 4);
        snap(1, 8'h23, 8'h59, 8'h12, 4'b0, 1'b0);
        press(B_UP);
        snap(1, 8'h00, 8'h59, 8'h12, 4'b0, 1'b0);
        press_n(B_MODE, 2);
        press_n(B_DOWN, 12);
        snap(3, 8'h00, 8'h59, 8'h00, 4'b0, 1'b0);
        press(B_DOWN);
        snap(3, 8'h00, 8'h59, 8'h59, 4'b0, 1'b0);
        press_n(B_UP, 10);
        snap(3, 8'h00, 8'h59, 8'h09, 4'b0, 1'b0);
        press(B_UP);
        snap(3, 8'h00, 8'h59, 8'h10, 4'b0, 1'b0);

        // 3: preset 00:00:03 and start, cycle-exact sequencer timing
        push_cmd(K_SET, 8'h00, 8'h59, 8'h10);
        press(B_MODE);
        wait_idle();
        press_n(B_MODE, 2);
        press(B_UP);
        press(B_MODE);
        press_n(B_DOWN, 7);
        snap(3, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        push_cmd(K_SET, 8'h00, 8'h00, 8'h03);
        push_cmd(K_PLAY, 8'h00, 8'h00, 8'h03);
        press(B_START);
        for (int i = 0; i < 9; i++) begin
            btn_up = (i == 2);
            snap(4, 8'h00, 8'h00, 8'h03, SEQ_CMD[i], SEQ_BUSY[i]);
        end
        btn_up = 1'b0;

        // 4: pause / resume / abort
        push_cmd(K_STOP, 8'h00, 8'h00, 8'h03);
        press(B_START);
        wait_idle();
        snap(5, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        ring = 1'b1;
        @(posedge clk); #1;
        ring = 1'b0;
        snap(5, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        push_cmd(K_PLAY, 8'h00, 8'h00, 8'h03);
        press(B_START);
        wait_idle();
        snap(4, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        push_cmd(K_RESET, 8'h00, 8'h00, 8'h03);
        press(B_MODE);
        wait_idle();
        snap(0, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);

        // 5: alarm flashing and acknowledge
        push_cmd(K_SET, 8'h00, 8'h00, 8'h03);
        push_cmd(K_PLAY, 8'h00, 8'h00, 8'h03);
        press(B_START);
        wait_idle();
        snap(4, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        ring = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) snap(6, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);
        push_cmd(K_SET, 8'h00, 8'h00, 8'h03);
        press(B_DOWN);
        ring = 1'b0;
        wait_idle();
        snap(0, 8'h00, 8'h00, 8'h03, 4'b0, 1'b0);

        // 6: start beats mode, then reset during the second play cycle
        press_n(B_MODE, 3);
        press_n(B_UP, 2);
        push_cmd(K_SET, 8'h00, 8'h00, 8'h05);
        press(B_MODE);
        wait_idle();
        snap(0, 8'h00, 8'h00, 8'h05, 4'b0, 1'b0);
        push_cmd(K_SET, 8'h00, 8'h00, 8'h05);
        push_cmd(K_PLAY, 8'h00, 8'h00, 8'h05);
        press(B_START | B_MODE);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rst = 1'b1;
            snap(4, 8'h00, 8'h00, 8'h05, SEQ_CMD[i], SEQ_BUSY[i]);
        end
        rst = 1'b0;
        blink_ref = cyc;
        snap(0, 8'h00, 8'h00, 8'h00, 4'b0, 1'b0);

        // zero preset: start is ignored
        press(B_START);
        for (int i = 0; i < 4; i++) snap(0, 8'h00, 8'h00, 8'h00, 4'b0, 1'b0);

        done = 1'b1;
    end

    // Monitor: sole owner of the counters
    initial begin : mon
        snap_t e_s, g_s;
        cmd_t  e_c, g_c;
        logic [3:0] cmds, prev_cmds;
        logic gap_pend, prev_busy, prev_rst;
        int run, low_cnt, snap_no;
        prev_cmds = 4'b0; gap_pend = 1'b0; prev_busy = 1'b0; prev_rst = 1'b1;
        run = 0; low_cnt = 0; snap_no = 0;
        forever begin
            @(negedge clk);
            cmds = {set, play, stop, reset};
            if (tmo) begin
                n_vec++; n_bad++;
                $display("FAIL timeout: cmd_busy still high after 40 cycles");
            end
            if (snap_req) begin
                n_vec++; snap_no++;
                g_s = {state_code, hour_bcd, minute_bcd, second_bcd, field_blank, cmds, cmd_busy};
                if (snap_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL snap%0d: no expected entry", snap_no);
                end else begin
                    e_s = snap_q.pop_front();
                    if (g_s !== e_s)  begin
                        n_bad++;
                        $display("FAIL snap%0d st/h:m:s/blank/cmd/busy got %0d %h:%h:%h %b %b %b want %0d %h:%h:%h %b %b %b",
                                 snap_no, g_s.st, g_s.h, g_s.m, g_s.s, g_s.blank, g_s.cmds, g_s.busy,
                                 e_s.st, e_s.h, e_s.m, e_s.s, e_s.blank, e_s.cmds, e_s.busy);
                    end
                end
            end
            if (cmds != 4'b0) begin
                n_vec++;
                if (!$onehot(cmds)) begin
                    n_bad++;
                    $display("FAIL onehot: cmds got %b want one-hot", cmds);
                end
            end
            if (cmds != 4'b0 && prev_cmds == 4'b0) begin
                n_vec++;
                g_c = {cmds, hour_bcd, minute_bcd, second_bcd};
                if (cmd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL cmd: unexpected pulse got %b", cmds);
                end else begin
                    e_c = cmd_q.pop_front();
                    if (g_c !== e_c) begin
                        n_bad++;
                        $display("FAIL cmd kind/preset got %b %h:%h:%h want %b %h:%h:%h",
                                 g_c.kind, g_c.h, g_c.m, g_c.s, e_c.kind, e_c.h, e_c.m, e_c.s);
                    end
                end
                if (gap_pend) begin
                    n_vec++;
                    if (low_cnt != GAP) begin
                        n_bad++;
                        $display("FAIL gap: got %0d low cycles want %0d", low_cnt, GAP);
                    end
                end
                gap_pend = 1'b0;
                run = 1;
            end else if (cmds != 4'b0) begin
                run++;
            end
            if (cmds == 4'b0 && prev_cmds != 4'b0) begin
                n_vec++;
                if (run != PULSE) begin
                    n_bad++;
                    $display("FAIL width: got %0d cycles want %0d", run, PULSE);
                end
                low_cnt  = cmd_busy ? 1 : 0;
                gap_pend = cmd_busy;
            end else if (cmds == 4'b0 && cmd_busy) begin
                low_cnt++;
            end
            if (!cmd_busy && prev_busy && !prev_rst) begin
                n_vec++;
                if (low_cnt != GAP) begin
                    n_bad++;
                    $display("FAIL tail gap: got %0d busy-low cycles want %0d", low_cnt, GAP);
                end
            end
            if (!cmd_busy) gap_pend = 1'b0;
            prev_cmds = cmds;
            prev_busy = cmd_busy;
            prev_rst  = rst;
            if (done) begin
                n_vec++;
                if (cmd_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: got %0d unissued commands want 0", cmd_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule

// File: doc/timer_preset_controller.md
Name: timer_preset_controller

Overview:
User-facing front end that drives count_down_timer from the opposite side of its interface. It turns debounced single-cycle button pulses into edited BCD preset values (hh:mm:ss) and timed set/play/stop/reset command pulses. It watches the timer's ring/counting feedback and produces per-field blanking for the 7-segment display driver. It sits between the button debouncers and count_down_timer, at clock rate clk (5 MHz).

Parameters:
CLK_HZ, 5000000, clk frequency in Hz
BLINK_HZ, 2, blink rate of the field under edit
PULSE_CYCLES, 2, high width of each command pulse (timer edge-detects; ≥2 required)
GAP_CYCLES, 2, low cycles between back-to-back command pulses

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_mode  in  1  one-cycle pulse: enter edit / next field / abort
btn_up  in  1  one-cycle pulse: increment field under edit
btn_down  in  1  one-cycle pulse: decrement field under edit
btn_start  in  1  one-cycle pulse: start / pause / resume
ring  in  1  timer alarm flag
counting  in  1  timer running flag (status only)
hour_bcd  out  8  preset hours, BCD 00-23, to timer hour_bcd_in
minute_bcd  out  8  preset minutes, BCD 00-59
second_bcd  out  8  preset seconds, BCD 00-59
set  out  1  command pulse: load preset
play  out  1  command pulse: start/resume
stop  out  1  command pulse: pause
reset  out  1  command pulse: clear timer
field_blank  out  3  {h,m,s}; 1 = display blanks that field this cycle
cmd_busy  out  1  command sequencer active; buttons ignored
state_code  out  3  current state, for debug

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all BCD outputs 8'h00; set/play/stop/reset 0; field_blank 000; cmd_busy 0; blink phase = visible; sequencer empty.
- States and codes: IDLE=0, EDIT_H=1, EDIT_M=2, EDIT_S=3, RUNNING=4, PAUSED=5, ALARM=6.
- Button priority when pulses coincide: start > mode > up > down. At most one action per cycle.
- All buttons are ignored while cmd_busy=1.
- IDLE:
  - mode -> EDIT_H.
  - start with preset ≠ 00:00:00 -> queue {set, play}, then RUNNING.
  - start with preset 00:00:00 is ignored.
- EDIT_H/M/S:
  - up/down change only the selected field, in BCD.
  - Hours wrap 23->00 on up and 00->23 on down. Minutes and seconds wrap 59->00 and 00->59.
  - Low nibble stays 0-9 at all times; no binary intermediate ever appears on the outputs.
  - mode advances H->M->S. Mode in EDIT_S queues {set} and returns to IDLE.
  - start queues {set, play} and goes to RUNNING; a zero preset is ignored as in IDLE.
- RUNNING:
  - start -> queue {stop}, go to PAUSED.
  - mode -> queue {reset}, go to IDLE.
  - ring=1 -> ALARM. ring has priority over same-cycle buttons.
- PAUSED:
  - start -> queue {play}, go to RUNNING.
  - mode -> queue {reset}, go to IDLE.
  - ring is ignored.
- ALARM: any button -> queue {set} (reloads preset, which clears ring), go to IDLE. Preset values are retained.
- Command sequencer:
  - Each queued command drives its output high for exactly PULSE_CYCLES.
  - Consecutive commands are separated by exactly GAP_CYCLES low.
  - First pulse rises on the cycle after the accepting button cycle.
  - cmd_busy is high from that cycle through the last low gap cycle after the final pulse.
  - Only one command output is high at any time.
  - The state transition takes effect on the accepting cycle.
- BCD outputs hold steady during any set pulse and change only in EDIT states.
- Blink:
  - Free-running counter of half-period CLK_HZ/(2*BLINK_HZ) cycles toggles the blink phase.
  - In EDIT_x, the selected field's field_blank bit equals the phase (1 = hidden); other bits are 0.
  - Any up/down press restarts the counter with phase = visible.
  - In ALARM, field_blank = 111 when phase hidden, 000 when visible (whole display flashes).
  - In all other states, field_blank = 000.
- rst mid-sequence:
  - Aborts the sequencer immediately; all command outputs are 0 on the next cycle.
  - State returns to IDLE and presets clear to 00:00:00. No trailing pulse is emitted.

Test Plan:
1. rst, then mode, up ×3, mode, down ×1, mode, up ×12 -> hour_bcd=8'h03, minute_bcd=8'h59, second_bcd=8'h12, state EDIT_S.
2. Wrap checks: EDIT_H at 8'h23 + up -> 8'h00; EDIT_S at 8'h00 + down -> 8'h59; 8'h09 + up -> 8'h10.
3. Preset 00:00:03, start with PULSE_CYCLES=2, GAP_CYCLES=2:
   - set high on cycles 1-2, low 3-4; play high 5-6.
   - cmd_busy high cycles 1-8; state RUNNING.
   - btn_up at cycle 3 ignored.
4. RUNNING: start -> stop 2-cycle pulse, PAUSED. Start again -> play pulse, RUNNING. Mode -> reset pulse, IDLE, preset unchanged.
5. RUNNING and ring rises -> ALARM; field_blank alternates 111/000 every CLK_HZ/(2*BLINK_HZ) cycles (sim CLK_HZ=8, BLINK_HZ=1 -> 4 cycles). btn_down -> set pulse, IDLE.
6. start and mode same cycle in IDLE with preset 00:00:05 -> start wins, RUNNING. rst asserted on the 2nd play cycle -> play=0 next cycle, outputs 00:00:00, state IDLE.
